// File: rtl/dll_seq_pkg.sv
// dll_seq_pkg: state encoding and counter sizing shared by the DLL lock sequencer.
package dll_seq_pkg;

    typedef enum logic [2:0] {IDLE, HOLD, WAIT_LOCK, FILTER, LOCKED, FAILED} state_e;

    localparam int SYNC_STAGES = 2;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/dll_lock_seq.sv
// dll_lock_seq: pulses the DLL reset, qualifies LOCKED over a filter window,
// retries on timeout and parks in FAILED once the retry budget is spent.
module dll_lock_seq
    import dll_seq_pkg::*;
#(
    parameter  int RST_HOLD_CYCLES = 8,
    parameter  int LOCK_TIMEOUT    = 4096,
    parameter  int LOCK_FILTER     = 16,
    parameter  int MAX_RETRIES     = 3,
    localparam int RW              = cnt_w(MAX_RETRIES + 1)
) (
    input  logic          clkin_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          locked_in_i,
    output logic          dll_rst_o,
    output logic          ready_o,
    output logic          sys_rst_o,
    output logic          fail_o,
    output logic          lock_lost_o,
    output logic [RW-1:0] retry_cnt_o
);

    localparam int HW = cnt_w(RST_HOLD_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam int FW = cnt_w(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] to_q, to_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          dll_rst_q, dll_rst_d;
    logic          ready_q, ready_d;
    logic          sys_rst_q;
    logic          fail_q, fail_d;
    logic          lost_q, lost_d;
    logic          lock_s;

    sync_2ff u_sync (
        .clk_i (clkin_i),
        .rst_i (rst_i),
        .d_i   (locked_in_i),
        .q_o   (lock_s)
    );

    always_ff @(posedge clkin_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            to_q      <= '0;
            filt_q    <= '0;
            retry_q   <= '0;
            dll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            sys_rst_q <= 1'b1;
            fail_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            filt_q    <= filt_d;
            retry_q   <= retry_d;
            dll_rst_q <= dll_rst_d;
            ready_q   <= ready_d;
            sys_rst_q <= ~ready_d;
            fail_q    <= fail_d;
            lost_q    <= lost_d;
        end
    end

    // Counters only advance while below their terminal value, so they saturate by construction.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        to_d    = to_q;
        filt_d  = filt_q;
        retry_d = retry_q;
        if (!en_i) begin
            state_d = IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = HOLD;
                    hold_d  = '0;
                    to_d    = '0;
                end
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        to_d    = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                WAIT_LOCK, FILTER: begin
                    if (to_q == TO_LAST) begin
                        state_d = (retry_q < RETRY_MAX) ? HOLD : FAILED;
                        retry_d = (retry_q < RETRY_MAX) ? retry_q + 1'b1 : retry_q;
                        hold_d  = '0;
                    end else begin
                        to_d = to_q + 1'b1;
                        if (!lock_s) begin
                            state_d = WAIT_LOCK;
                            filt_d  = '0;
                        end else if (state_q == WAIT_LOCK) begin
                            state_d = FILTER;
                            filt_d  = '0;
                        end else if (filt_q == FILT_LAST) begin
                            state_d = LOCKED;
                            retry_d = '0;
                        end else begin
                            filt_d = filt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!lock_s) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
                FAILED:  state_d = FAILED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dll_rst_d = state_d inside {IDLE, HOLD, FAILED};
        ready_d   = state_d == LOCKED;
        fail_d    = state_d == FAILED;
        lost_d    = (state_q == LOCKED) && (state_d == HOLD);
    end

    assign dll_rst_o   = dll_rst_q;
    assign ready_o     = ready_q;
    assign sys_rst_o   = sys_rst_q;
    assign fail_o      = fail_q;
    assign lock_lost_o = lost_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: doc/dll_lock_seq.md
DLL_LOCK_SEQ -- requirements
Module: dll_lock_seq

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 8: cycles DLL_RST is held high per attempt; legal range 3..255.
REQ-002 Parameter LOCK_TIMEOUT, default 4096: maximum cycles from DLL_RST release to READY before an attempt fails.
REQ-003 Parameter LOCK_FILTER, default 16: consecutive synchronized-high LOCKED_IN cycles required before lock is declared; legal range 2..LOCK_TIMEOUT-1.
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts retried before entering FAILED.
REQ-005 CLKIN, input, 1: sole clock, the DLL input clock, rising edge.
REQ-006 RST, input, 1: asynchronous, active-high reset.
REQ-007 EN, input, 1: synchronous enable; high runs the sequence, low parks the block in IDLE.
REQ-008 LOCKED_IN, input, 1: DLL LOCKED output; treated as asynchronous.
REQ-009 DLL_RST, output, 1: drives the DLL RST pin, active-high.
REQ-010 READY, output, 1: high only while the lock is qualified.
REQ-011 SYS_RST, output, 1: active-high downstream reset; equals the inverse of READY.
REQ-012 FAIL, output, 1: high only in the FAILED state.
REQ-013 LOCK_LOST, output, 1: single-cycle pulse when a qualified lock drops.
REQ-014 RETRY_CNT, output, 2 bits (clog2(MAX_RETRIES+1)): number of failed attempts in the current sequence.

Function
REQ-015 LOCKED_IN shall pass through a 2-flop synchronizer; all logic uses the synchronized value (lock_s).
REQ-016 States and DLL_RST value:
- IDLE: DLL_RST=1.
- HOLD: DLL_RST=1.
- WAIT_LOCK: DLL_RST=0.
- FILTER: DLL_RST=0.
- LOCKED: DLL_RST=0.
- FAILED: DLL_RST=1.
REQ-017 IDLE -> HOLD when EN=1; the hold counter and timeout counter are cleared.
REQ-018 HOLD shall last exactly RST_HOLD_CYCLES cycles, then go to WAIT_LOCK with the timeout counter at 0.
REQ-019 WAIT_LOCK -> FILTER on lock_s=1, with the filter counter at 0; the timeout counter runs in both WAIT_LOCK and FILTER.
REQ-020 FILTER -> WAIT_LOCK on lock_s=0, with the filter counter cleared.
REQ-021 FILTER -> LOCKED when lock_s=1 and the filter counter equals LOCK_FILTER-1.
REQ-022 Timeout expiry in WAIT_LOCK or FILTER:
- If RETRY_CNT<MAX_RETRIES: increment RETRY_CNT and go to HOLD.
- Otherwise: go to FAILED.
REQ-023 Timeout shall take priority over the FILTER->LOCKED transition on the same cycle.
REQ-024 On entry to LOCKED, RETRY_CNT shall clear to 0.
REQ-025 LOCKED -> HOLD on lock_s=0; LOCK_LOST pulses for exactly that one cycle.
REQ-026 FAILED is sticky; its only exits are RST, or EN=0 (-> IDLE).
REQ-027 EN=0 in any state shall force IDLE on the next edge, clear RETRY_CNT, and suppress LOCK_LOST; EN=0 overrides all other transitions.
REQ-028 All outputs shall be registered, glitch-free decodes of the next state.
REQ-029 READY latency: LOCKED_IN rising (stable) before edge e1 in WAIT_LOCK gives READY=1 after edge e1+2+LOCK_FILTER (19 edges at default).
REQ-030 Counters shall saturate and never wrap.

Reset
REQ-031 RST asserted shall asynchronously set:
- state=IDLE, all counters=0, synchronizer flops=0;
- DLL_RST=1, SYS_RST=1, READY=0, FAIL=0, LOCK_LOST=0, RETRY_CNT=0.
REQ-032 Release from RST shall be synchronous to CLKIN through the state register; the first transition out of IDLE occurs no earlier than the first edge after release.
REQ-033 RST mid-sequence, including in LOCKED or FAILED, shall abort immediately with no LOCK_LOST pulse.

Structure
REQ-034 Package dll_seq_pkg shall hold the state enum (IDLE, HOLD, WAIT_LOCK, FILTER, LOCKED, FAILED) and the counter-width functions and constants.
REQ-035 The synchronizer shall be sub-module sync_2ff (1-bit, async active-high reset to 0); there are no other sub-modules.

Verification
REQ-036 Defaults, EN=1, LOCKED_IN rises 100 cycles after DLL_RST falls -> DLL_RST high for exactly 8 cycles, READY=1 19 edges after LOCKED_IN rises, RETRY_CNT=0.
REQ-037 LOCKED_IN never rises -> 4 attempts, each with an 8-cycle DLL_RST pulse; RETRY_CNT steps 1,2,3; then FAIL=1 and DLL_RST=1 held; EN low for one cycle -> IDLE, FAIL=0.
REQ-038 LOCKED_IN high for 10 cycles, low for 1, then high steadily -> FILTER restarts; READY asserts 19 edges after the final rise; no retry is counted.
REQ-039 In LOCKED, LOCKED_IN drops -> one-cycle LOCK_LOST, READY=0, SYS_RST=1, DLL_RST=1 for 8 cycles, then relock succeeds.
REQ-040 LOCK_TIMEOUT=20, LOCK_FILTER=16, LOCKED_IN rises at timeout cycle 3 -> timeout wins, RETRY_CNT=1, READY stays 0.
REQ-041 RST asserted asynchronously mid-FILTER and mid-LOCKED -> outputs reach reset values before the next edge; no LOCK_LOST pulse.
